// File: rtl/fifo_sync_param.sv
// ----------------------------------------------------------------------------
// fifo_sync_param
//
// Parametrised single-clock synchronous FIFO with a show-ahead read port.
// Storage is a circular buffer addressed by free-running read/write pointers
// that wrap modulo DEPTH. A separate occupancy counter drives every status
// flag, so no status output has a combinational path from we/re.
//
// Parameters:
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries (power of two, >= 2)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset, discards all contents
//   clr           synchronous flush, overrides we/re in the same cycle
//   data_in       write data
//   we            write request
//   re            read request, pops the current head
//   data_out      head entry (first-word fall-through), 0 when empty
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full without a read
//   underflow     sticky: read attempted while empty
//
// Build option:
//   FIFO_ERR_FLAGS_EN  when defined, overflow/underflow are sticky flag
//                      registers; when undefined they are tied to 0 and no
//                      flag registers exist.
// ----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       we,
    input  logic                       re,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic wr_ok;
    logic rd_ok;
    logic mem_we;

    // Status decodes come from the registered count only.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign data_out     = empty ? '0 : mem_q[rd_ptr_q];

    // A write into a full FIFO is accepted when a read frees the head slot in
    // the same cycle. A read on an empty FIFO is never accepted (no bypass).
    assign wr_ok  = we & (~full | re);
    assign rd_ok  = re & ~empty;
    assign mem_we = wr_ok & ~clr & ~rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset or flushed; only pointers move.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (we & full & ~re);
        underflow_d = underflow_q | (re & empty);
        if (clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock synchronous FIFO: the general-purpose successor to the GPU's fixed 16x32 command FIFO. Circular-buffer storage with read/write pointers and an occupancy counter, show-ahead (first-word fall-through) read port, programmable almost-full/almost-empty thresholds and optional sticky error flags. Used between the CPU bus interface and the GPU command decoder, and anywhere else a word queue of configurable width and depth is needed.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- clr  in  1  synchronous flush; priority over re/we
- data_in  in  WIDTH  write data
- we  in  1  write request
- re  in  1  read request (pops current head)
- data_out  out  WIDTH  head entry (show-ahead); 0 when empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full (see Configuration)
- underflow  out  1  sticky: read attempted while empty (see Configuration)

## Operation
- State: mem[DEPTH], wr_ptr and rd_ptr ($clog2(DEPTH) bits, wrap naturally modulo DEPTH), count register.
- Write accepted (wr_ok) = we & (~full | re). On wr_ok: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted (rd_ok) = re & ~empty. On rd_ok: rd_ptr++.
- count next = count + wr_ok - rd_ok.
- Full with re & we: both accepted, count stays DEPTH, pointers both advance.
- Empty with re & we: write accepted, read ignored (no bypass), count becomes 1.
- re alone on empty, we alone on full: ignored, no state change except error flags.
- clr: wr_ptr, rd_ptr, count <= 0; overflow/underflow <= 0; re/we that cycle ignored; mem contents not cleared.
- rst: same as clr; rst mid-stream discards all contents.
- All status outputs are combinational decodes of count; data_out = empty ? 0 : mem[rd_ptr].

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0 (AF_LEVEL>0), data_out 0, overflow 0, underflow 0.
- Write-to-read latency: word written at edge N is on data_out and empty deasserts after edge N (1 cycle) when FIFO was empty.
- Read: data_out shows next entry immediately after the popping edge.
- Flags and count change only on clock edges; no combinational path from re/we to status outputs. data_out depends only on registered state.
- Throughput: one write and one read per cycle sustained at any occupancy.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow sets when we & full & ~re; underflow sets when re & empty (including re&we on empty); both sticky until rst or clr.
- FIFO_ERR_FLAGS_EN undefined: overflow and underflow tied to 0, no flag registers.

## Test plan
- Reset, WIDTH=32 DEPTH=16: after rst, empty=1, count=0, data_out=0; write 0xA5A5_0001 -> next cycle data_out=0xA5A5_0001, count=1, empty=0.
- Fill 16 words 0..15 -> full=1, almost_full from count=14; extra we with 0xDEAD -> count=16, head still 0, overflow=1 (macro on) / 0 (off).
- Full, re & we with 0x100 for 20 cycles -> count stays 16, pops return 0..15 then 0x100.. in order across pointer wrap.
- Empty, re & we with 0x55 -> count=1, data_out=0x55, underflow=1 (macro on); plain re on empty -> no change.
- 8 entries, assert clr with we=1 -> count=0, empty=1, flags cleared, written word discarded.
- rst asserted mid-burst with re&we active -> next cycle all outputs at reset values.
